instr_mem_arbiter: RTL and testbench

Shares the single synchronous-read port of the instruction ROM between two requesters: the core fetch unit (port F) and the data-side load unit (port D), which reads constants and literal pools. Converts the ROM's fixed 1-cycle read latency into per-port req/gnt and rvalid/rready handshakes, with one response hold slot per port. It also range-checks addresses. Sits between the core's fetch/LSU and the ROM.

---
 rtl/instr_mem_arbiter_pkg.sv | 31 +++
 rtl/instr_mem_arbiter_if.sv | 50 +++++
 rtl/instr_mem_arbiter_resp_slot.sv | 77 +++++++
 rtl/instr_mem_arbiter.sv | 118 +++++++++++
 tb/tb_instr_mem_arbiter.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/instr_mem_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : instr_mem_pkg
// Purpose  : Shared constants, port identifiers and the ROM address range
//            check used by the instruction-ROM arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package instr_mem_pkg;

    // ROM word-index width; the ROM holds 2**ROM_AW 32-bit words.
    localparam int          ROM_AW   = 10;
    // Byte base address of the ROM window.
    localparam logic [31:0] ROM_BASE = 32'h0000_0000;

    typedef enum logic {
        PORT_F = 1'b0,
        PORT_D = 1'b1
    } port_e;

    // True when the word address falls inside the ROM window: every bit
    // above the word index must match the base address.
    function automatic logic in_range(input logic [30:2] addr,
                                      input int          aw   = ROM_AW,
                                      input logic [31:0] base = ROM_BASE);
        logic [30:2] diff;
        diff = addr ^ base[30:2];
        return ((diff >> aw) == '0);
    endfunction

endpackage
`default_nettype wire

// File: rtl/instr_mem_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : instr_mem_arbiter_if
// Purpose  : Request/response bundle for the fetch (F) and data (D) ports
//            plus the ROM read port of the instruction-ROM arbiter.
// Revision : 1.0 - initial release
// ============================================================================
interface instr_mem_arbiter_if;

    logic        f_req_i;
    logic [30:2] f_addr_i;
    logic        f_gnt_o;
    logic        f_rvalid_o;
    logic [31:0] f_rdata_o;
    logic        f_err_o;
    logic        f_rready_i;

    logic        d_req_i;
    logic [30:2] d_addr_i;
    logic        d_gnt_o;
    logic        d_rvalid_o;
    logic [31:0] d_rdata_o;
    logic        d_err_o;
    logic        d_rready_i;

    logic [30:2] rom_addr_o;
    logic [31:0] rom_rdata_i;

    // Arbiter view.
    modport slave (
        input  f_req_i, f_addr_i, f_rready_i,
        input  d_req_i, d_addr_i, d_rready_i,
        input  rom_rdata_i,
        output f_gnt_o, f_rvalid_o, f_rdata_o, f_err_o,
        output d_gnt_o, d_rvalid_o, d_rdata_o, d_err_o,
        output rom_addr_o
    );

    // Requester / ROM view.
    modport master (
        output f_req_i, f_addr_i, f_rready_i,
        output d_req_i, d_addr_i, d_rready_i,
        output rom_rdata_i,
        input  f_gnt_o, f_rvalid_o, f_rdata_o, f_err_o,
        input  d_gnt_o, d_rvalid_o, d_rdata_o, d_err_o,
        input  rom_addr_o
    );

endinterface
`default_nettype wire

// File: rtl/instr_mem_arbiter_resp_slot.sv
`default_nettype none
// ============================================================================
// Module   : resp_slot
// Purpose  : Per-port response path. Tracks the read issued last cycle,
//            presents it directly when the port is ready, and parks it in a
//            one-entry hold register when the port stalls.
// Revision : 1.0 - initial release
// ============================================================================
module resp_slot (
    input  wire logic        clk_i,
    input  wire logic        rst_i,
    input  wire logic        issue,
    input  wire logic        issue_err,
    input  wire logic [31:0] rom_rdata,
    input  wire logic        rready,
    output logic             rvalid,
    output logic [31:0]      rdata,
    output logic             err,
    output logic             eligible
);

    logic        r_inflight;
    logic        r_inflight_err;
    logic        r_full;
    logic        r_err;
    logic [31:0] r_data;
    logic [31:0] w_live_data;

    // Out-of-range reads never touch the ROM, so their data is forced to 0.
    assign w_live_data = r_inflight_err ? 32'h0 : rom_rdata;

    // Remember which cycle carries this port's ROM response.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_inflight     <= 1'b0;
            r_inflight_err <= 1'b0;
        end else begin
            r_inflight     <= issue;
            r_inflight_err <= issue & issue_err;
        end
    end

    // Park a stalled live response; release it once the port takes it.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_full <= 1'b0;
            r_err  <= 1'b0;
            r_data <= 32'h0;
        end else if (r_full) begin
            if (rready) begin
                r_full <= 1'b0;
            end
        end else if (r_inflight && !rready) begin
            r_full <= 1'b1;
            r_err  <= r_inflight_err;
            r_data <= w_live_data;
        end
    end

    // The hold register and a live response are never both occupied, since a
    // full slot blocks new issues.
    always_comb begin
        rvalid   = r_full | r_inflight;
        rdata    = 32'h0;
        err      = 1'b0;
        if (r_full) begin
            rdata = r_data;
            err   = r_err;
        end else if (r_inflight) begin
            rdata = w_live_data;
            err   = r_inflight_err;
        end
        eligible = !r_full && !(r_inflight && !rready);
    end

endmodule
`default_nettype wire

// File: rtl/instr_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : instr_mem_arbiter
// Purpose  : Shares the single synchronous-read instruction ROM port between
//            the fetch unit (F) and the data-side load unit (D), with
//            round-robin tie breaking and per-port response hold slots.
// Revision : 1.0 - initial release
// ============================================================================
module instr_mem_arbiter
    import instr_mem_pkg::*;
(
    input  wire logic          clk_i,
    input  wire logic          rst_i,
    instr_mem_arbiter_if.slave bus
);

    port_e       r_last_grant;
    port_e       w_last_grant_nxt;
    logic [30:2] r_rom_addr;
    logic        w_f_elig;
    logic        w_d_elig;
    logic        w_f_cand;
    logic        w_d_cand;
    logic        w_f_gnt;
    logic        w_d_gnt;
    logic        w_f_inr;
    logic        w_d_inr;

    assign w_f_inr = in_range(bus.f_addr_i);
    assign w_d_inr = in_range(bus.d_addr_i);

    // Arbitration: a lone candidate wins; a tie goes to the port not granted
    // last. Grants are suppressed while reset is asserted.
    always_comb begin
        w_f_cand         = bus.f_req_i && w_f_elig && !rst_i;
        w_d_cand         = bus.d_req_i && w_d_elig && !rst_i;
        w_f_gnt          = 1'b0;
        w_d_gnt          = 1'b0;
        w_last_grant_nxt = r_last_grant;
        if (w_f_cand && w_d_cand) begin
            if (r_last_grant == PORT_D) begin
                w_f_gnt          = 1'b1;
                w_last_grant_nxt = PORT_F;
            end else begin
                w_d_gnt          = 1'b1;
                w_last_grant_nxt = PORT_D;
            end
        end else begin
            w_f_gnt = w_f_cand;
            w_d_gnt = w_d_cand;
        end
    end

    // Tie-break history register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_last_grant <= PORT_D;
        end else begin
            r_last_grant <= w_last_grant_nxt;
        end
    end

    // ROM address follows the in-range winner in the grant cycle, else holds.
    always_comb begin
        bus.rom_addr_o = r_rom_addr;
        if (w_f_gnt && w_f_inr) begin
            bus.rom_addr_o = bus.f_addr_i;
        end else if (w_d_gnt && w_d_inr) begin
            bus.rom_addr_o = bus.d_addr_i;
        end
    end

    // Keep the last ROM address for cycles without a ROM access.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_rom_addr <= '0;
        end else begin
            r_rom_addr <= bus.rom_addr_o;
        end
    end

    assign bus.f_gnt_o = w_f_gnt;
    assign bus.d_gnt_o = w_d_gnt;

    resp_slot u_f_slot (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .issue     (w_f_gnt),
        .issue_err (!w_f_inr),
        .rom_rdata (bus.rom_rdata_i),
        .rready    (bus.f_rready_i),
        .rvalid    (bus.f_rvalid_o),
        .rdata     (bus.f_rdata_o),
        .err       (bus.f_err_o),
        .eligible  (w_f_elig)
    );

    resp_slot u_d_slot (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .issue     (w_d_gnt),
        .issue_err (!w_d_inr),
        .rom_rdata (bus.rom_rdata_i),
        .rready    (bus.d_rready_i),
        .rvalid    (bus.d_rvalid_o),
        .rdata     (bus.d_rdata_o),
        .err       (bus.d_err_o),
        .eligible  (w_d_elig)
    );

    // A pending request must keep its address until it is granted.
    f_addr_stable: assert property (@(posedge clk_i) disable iff (rst_i)
        ($past(bus.f_req_i && !bus.f_gnt_o) && bus.f_req_i) |-> $stable(bus.f_addr_i));
    d_addr_stable: assert property (@(posedge clk_i) disable iff (rst_i)
        ($past(bus.d_req_i && !bus.d_gnt_o) && bus.d_req_i) |-> $stable(bus.d_addr_i));

endmodule
`default_nettype wire

// File: tb/tb_instr_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_instr_mem_arbiter
// Purpose  : Scoreboard bench for instr_mem_arbiter with a synchronous ROM
//            model and directed request sequences on both ports.
// Revision : 1.0 - initial release
// ============================================================================
module tb_instr_mem_arbiter;

    typedef struct packed {
        logic [31:0] data;
        logic        err;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    bit   log_en = 1'b0;

    exp_t q_f[$];
    exp_t q_d[$];
    int   glog[$];
    logic [31:0] rom_mem [1024];

    instr_mem_arbiter_if bus ();

    instr_mem_arbiter dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Cycle counter for latency/throughput checks.
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] rom_word(input int i);
        return (i == 0) ? 32'h8000_0537 : 32'h1357_0000 + 32'(i) * 32'h103;
    endfunction

    function automatic exp_t expect_for(input logic [31:0] baddr);
        exp_t e;
        if (baddr < 32'h1000) begin
            e.data = rom_word(int'(baddr[11:2]));
            e.err  = 1'b0;
        end else begin
            e.data = 32'h0;
            e.err  = 1'b1;
        end
        return e;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // ROM model: one-cycle synchronous read.
    initial for (int i = 0; i < 1024; i++) rom_mem[i] = rom_word(i);
    always @(posedge clk) bus.rom_rdata_i <= rom_mem[bus.rom_addr_o[11:2]];

    // Monitor: compare every delivered response against the scoreboard.
    always @(negedge clk) begin
        exp_t e;
        if (bus.f_rvalid_o && bus.f_rready_i) begin
            if (q_f.size() == 0) check("f_unexpected_rvalid", 32'd1, 32'd0);
            else begin
                e = q_f.pop_front();
                check("f_rdata", bus.f_rdata_o, e.data);
                check("f_err", {31'd0, bus.f_err_o}, {31'd0, e.err});
            end
        end
        if (bus.d_rvalid_o && bus.d_rready_i) begin
            if (q_d.size() == 0) check("d_unexpected_rvalid", 32'd1, 32'd0);
            else begin
                e = q_d.pop_front();
                check("d_rdata", bus.d_rdata_o, e.data);
                check("d_err", {31'd0, bus.d_err_o}, {31'd0, e.err});
            end
        end
        if (log_en && (bus.f_gnt_o || bus.d_gnt_o))
            glog.push_back(bus.f_gnt_o && bus.d_gnt_o ? 2 : (bus.d_gnt_o ? 1 : 0));
    end

    // Issue one request on port p (0=F, 1=D) and wait for its grant.
    task automatic do_req(input bit p, input logic [31:0] baddr);
        int n;
        if (p == 1'b0) begin
            q_f.push_back(expect_for(baddr));
            bus.f_addr_i = baddr[30:2];
            bus.f_req_i  = 1'b1;
        end else begin
            q_d.push_back(expect_for(baddr));
            bus.d_addr_i = baddr[30:2];
            bus.d_req_i  = 1'b1;
        end
        n = 0;
        forever begin
            @(negedge clk);
            if (p ? bus.d_gnt_o : bus.f_gnt_o) break;
            n++;
            if (n > 40) begin
                check(p ? "d_gnt_timeout" : "f_gnt_timeout", 32'd0, 32'd1);
                break;
            end
        end
        @(posedge clk); #1;
        if (p == 1'b0) bus.f_req_i = 1'b0;
        else           bus.d_req_i = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_f_rvalid"}, {31'd0, bus.f_rvalid_o}, 32'd0);
        check({tag, "_d_rvalid"}, {31'd0, bus.d_rvalid_o}, 32'd0);
        check({tag, "_f_gnt"},    {31'd0, bus.f_gnt_o},    32'd0);
        check({tag, "_d_gnt"},    {31'd0, bus.d_gnt_o},    32'd0);
        check({tag, "_f_err"},    {31'd0, bus.f_err_o},    32'd0);
        check({tag, "_d_err"},    {31'd0, bus.d_err_o},    32'd0);
        check({tag, "_f_rdata"},  bus.f_rdata_o,           32'd0);
        check({tag, "_d_rdata"},  bus.d_rdata_o,           32'd0);
        check({tag, "_rom_addr"}, {3'd0, bus.rom_addr_o},  32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        int t0;
        bus.f_req_i = 1'b0; bus.f_addr_i = '0; bus.f_rready_i = 1'b1;
        bus.d_req_i = 1'b0; bus.d_addr_i = '0; bus.d_rready_i = 1'b1;
        #1 rst = 1'b1;
        #1 check_all_zero("reset");
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // F alone streams words 0..15 at one grant per cycle.
        t0 = cyc;
        for (int i = 0; i < 16; i++) do_req(1'b0, 32'(i * 4));
        check("t1_cycles", 32'(cyc - t0), 32'd16);
        repeat (3) @(posedge clk); #1;

        // Both ports contend every cycle: strict F,D alternation.
        log_en = 1'b1;
        fork
            begin for (int i = 0; i < 8; i++) do_req(1'b0, 32'h000); end
            begin for (int i = 0; i < 8; i++) do_req(1'b1, 32'h040); end
        join
        log_en = 1'b0;
        check("t2_grant_count", 32'(glog.size()), 32'd16);
        for (int i = 0; i < 16 && i < glog.size(); i++)
            check("t2_grant_order", 32'(glog[i]), 32'(i % 2));
        repeat (3) @(posedge clk); #1;

        // D stalls its response for 3 cycles while F keeps streaming.
        bus.d_rready_i = 1'b0;
        do_req(1'b1, 32'h000);
        fork
            begin
                int tf;
                tf = cyc;
                for (int i = 0; i < 4; i++) do_req(1'b0, 32'(32'h100 + i * 4));
                check("t3_f_cycles", 32'(cyc - tf), 32'd4);
            end
            begin
                int n;
                q_d.push_back(expect_for(32'h004));
                bus.d_addr_i = 29'd1;
                bus.d_req_i  = 1'b1;
                repeat (3) begin
                    @(negedge clk);
                    check("t3_d_rvalid_held", {31'd0, bus.d_rvalid_o}, 32'd1);
                    check("t3_d_rdata_held", bus.d_rdata_o, 32'h8000_0537);
                    check("t3_d_gnt_stalled", {31'd0, bus.d_gnt_o}, 32'd0);
                end
                @(posedge clk); #1 bus.d_rready_i = 1'b1;
                n = 0;
                forever begin
                    @(negedge clk);
                    if (bus.d_gnt_o) break;
                    n++;
                    if (n > 40) begin check("t3_d_gnt_timeout", 32'd0, 32'd1); break; end
                end
                @(posedge clk); #1 bus.d_req_i = 1'b0;
            end
        join
        repeat (3) @(posedge clk); #1;

        // D reads outside the ROM window: granted at once, error response.
        t0 = cyc;
        do_req(1'b1, 32'h0000_1000);
        check("t4_gnt_latency", 32'(cyc - t0), 32'd1);
        repeat (3) @(posedge clk); #1;

        // Reset with an F read in flight and a D response held.
        bus.d_rready_i = 1'b0;
        do_req(1'b1, 32'h008);
        do_req(1'b0, 32'h00C);
        rst = 1'b1;
        q_f.delete();
        q_d.delete();
        bus.f_addr_i = 29'h5; bus.f_req_i = 1'b1;
        bus.d_addr_i = 29'h6; bus.d_req_i = 1'b1;
        bus.d_rready_i = 1'b1;
        #1 check_all_zero("t5_reset");
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        q_f.push_back(expect_for(32'h014));
        q_d.push_back(expect_for(32'h018));
        @(negedge clk);
        check("t5_no_stale_f_rvalid", {31'd0, bus.f_rvalid_o}, 32'd0);
        check("t5_no_stale_d_rvalid", {31'd0, bus.d_rvalid_o}, 32'd0);
        check("t5_tie_f_gnt", {31'd0, bus.f_gnt_o}, 32'd1);
        check("t5_tie_d_gnt", {31'd0, bus.d_gnt_o}, 32'd0);
        @(posedge clk); #1 bus.f_req_i = 1'b0;
        @(negedge clk);
        check("t5_then_d_gnt", {31'd0, bus.d_gnt_o}, 32'd1);
        @(posedge clk); #1 bus.d_req_i = 1'b0;

        repeat (4) @(posedge clk); #1;
        check("drain_f_queue", 32'(q_f.size()), 32'd0);
        check("drain_d_queue", 32'(q_d.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
